// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M execute unit (MUL, MULH, MULHSU, MULHU, DIV,
//               DIVU). Shift-add multiply and restoring divide on operand
//               magnitudes, one bit per cycle, with a registered result and
//               a one-cycle done pulse. Non-M codes complete immediately with
//               a zero result.
//               Optional macro FAST_MUL_EN: multiplies use a single-cycle
//               33x33 signed multiplier; divides stay iterative.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic            iFlush,
  input  logic [4:0]      iControlSignal,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  // ALU control codes for the M extension (contiguous block in the decoder)
  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHSU = 5'd13;
  localparam logic [4:0] OPMULHU  = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        code_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;       // {partial product | remainder, multiplier | quotient}
  logic [XLEN-1:0]   result_q, result_d;

  // ---------------- Operand decode at the accept edge ----------------
  logic            w_in_m, w_in_div, w_in_mul;
  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_accept, w_fast, w_go_calc;
  logic [XLEN-1:0] w_fast_res;

  assign w_in_m     = (iControlSignal >= OPMUL) && (iControlSignal <= OPDIVU);
  assign w_in_div   = (iControlSignal == OPDIV) || (iControlSignal == OPDIVU);
  assign w_in_mul   = w_in_m && !w_in_div;
  // MUL low bits are identical for any signedness, so treat it as signed*signed
  assign w_a_signed = (iControlSignal == OPMUL) || (iControlSignal == OPMULH) ||
                      (iControlSignal == OPMULHSU) || (iControlSignal == OPDIV);
  assign w_b_signed = (iControlSignal == OPMUL) || (iControlSignal == OPMULH) ||
                      (iControlSignal == OPDIV);
  assign w_a_neg    = w_a_signed && iA[XLEN-1];
  assign w_b_neg    = w_b_signed && iB[XLEN-1];
  assign w_mag_a    = w_a_neg ? (~iA + 1'b1) : iA;
  assign w_mag_b    = w_b_neg ? (~iB + 1'b1) : iB;

  // A start in CALC is ignored; a flush always wins over a start
  assign w_accept   = iStart && !iFlush && (state_q != S_CALC);

`ifdef FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN+1:0] w_fast_full;
  logic                     w_unused_fast;
  assign w_fa          = $signed({w_a_signed & iA[XLEN-1], iA});
  assign w_fb          = $signed({w_b_signed & iB[XLEN-1], iB});
  assign w_fast_full   = w_fa * w_fb;
  assign w_unused_fast = ^w_fast_full[2*XLEN+1:2*XLEN];
  assign w_fast        = w_in_mul;
  assign w_fast_res    = (iControlSignal == OPMUL) ? w_fast_full[XLEN-1:0]
                                                   : w_fast_full[2*XLEN-1:XLEN];
`else
  assign w_fast        = 1'b0;
  assign w_fast_res    = '0;
`endif

  assign w_go_calc = w_in_m && !w_fast;

  // ---------------- One iteration of the datapath ----------------
  logic            w_code_div;
  logic [XLEN:0]   w_sum, w_diff;
  logic            w_ge;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_step, w_prod;
  logic [XLEN-1:0] w_quo, w_final;
  logic            w_calc_last;

  assign w_code_div = (code_q == OPDIV) || (code_q == OPDIVU);

  // Shift-add: conditionally add multiplicand to the upper half, shift right
  assign w_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {w_sum, acc_q[XLEN-1:1]};

  // Restoring divide: shift next dividend bit into the remainder, trial subtract
  assign w_diff     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
  assign w_ge       = !w_diff[XLEN];
  assign w_div_next = {(w_ge ? w_diff[XLEN-1:0] : {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]}),
                       acc_q[XLEN-2:0], w_ge};

  assign w_step     = w_code_div ? w_div_next : w_mul_next;

  // Sign fix-up of the finished magnitude result
  assign w_prod     = neg_q ? (~w_step + 1'b1) : w_step;
  assign w_quo      = neg_q ? (~w_step[XLEN-1:0] + 1'b1) : w_step[XLEN-1:0];
  assign w_calc_last = (state_q == S_CALC) && (cnt_q == C_LAST);

  // Final value: divide-by-zero yields all ones; signed overflow falls out naturally
  always_comb begin
    w_final = '0;
    if (w_code_div)
      w_final = (opnd_q == '0) ? '1 : w_quo;
    else if (code_q == OPMUL)
      w_final = w_prod[XLEN-1:0];
    else
      w_final = w_prod[2*XLEN-1:XLEN];
  end

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (iFlush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (iStart) state_d = w_go_calc ? S_CALC : S_DONE;
        S_CALC:  if (cnt_q == C_LAST) state_d = S_DONE;
        S_DONE:  state_d = iStart ? (w_go_calc ? S_CALC : S_DONE) : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    oBusy   = (state_q == S_CALC);
    oDone   = (state_q == S_DONE);
    oResult = result_q;
  end

  // ---------------- Datapath registers ----------------
  // Latch operands on accept, iterate in CALC unless flushed
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q  <= '0;
      code_q <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
    end else if (w_accept) begin
      cnt_q  <= '0;
      code_q <= iControlSignal;
      neg_q  <= w_a_neg ^ w_b_neg;
      if (w_in_div) begin
        opnd_q <= w_mag_b;
        acc_q  <= {{XLEN{1'b0}}, w_mag_a};
      end else begin
        opnd_q <= w_mag_a;
        acc_q  <= {{XLEN{1'b0}}, w_mag_b};
      end
    end else if ((state_q == S_CALC) && !iFlush) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= w_step;
    end
  end

  // Result is only updated on entry to DONE; a flush leaves it untouched
  always_comb begin
    result_d = result_q;
    if (w_accept) begin
      if (!w_in_m)
        result_d = '0;
      else if (w_fast)
        result_d = w_fast_res;
    end else if (w_calc_last && !iFlush) begin
      result_d = w_final;
    end
  end

  // Result register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) result_q <= '0;
    else      result_q <= result_d;
  end

endmodule
`default_nettype wire
